// File: rtl/mpt_pkg.sv
// Shared MPT types: supervisor physical address, access kinds, walk fault
// codes, and the walker arbiter state encoding.
package mpt_pkg;

  localparam int unsigned SPA_W = 56;

  typedef union packed {
    logic [SPA_W-1:0] raw;
    struct packed {
      logic [SPA_W-13:0] ppn;
      logic [11:0]       offset;
    } fields;
  } spa_t_u;

  typedef enum logic [1:0] {
    MPT_ACCESS_READ  = 2'd0,
    MPT_ACCESS_WRITE = 2'd1,
    MPT_ACCESS_EXEC  = 2'd2
  } mpt_access_e;

  // FMT_NO_FAULT is zero so a cleared result register reads as "no fault".
  typedef enum logic [1:0] {
    FMT_NO_FAULT      = 2'd0,
    FMT_BAD_MODE      = 2'd1,
    FMT_RESERVED_BITS = 2'd2,
    FMT_BAD_PTE       = 2'd3
  } page_format_fault_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_BUSY  = 2'd2
  } mptw_arb_state_e;

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: first valid requester at or after ptr, wrapping.
module rr_select #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan N_REQ positions starting from ptr; the first hit wins.
  always_comb begin
    int unsigned j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!any && valid[IDX_W'(j)]) begin
        any                = 1'b1;
        grant[IDX_W'(j)]   = 1'b1;
        idx                = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mptw_arbiter.sv
// Shares one MPT walker between N_REQ requesters with round-robin fairness.
// Handshake: a requester's walk is accepted in the cycle req_ready_o[i]
// pulses while req_valid_i[i] is high; the walker takes the transaction in
// the cycle walker_valid_o && walker_ready_i; the response is a single-cycle
// rsp_valid_o pulse with no backpressure.
module mptw_arbiter
  import mpt_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           mptw_enable_i,
  input  logic [N_REQ-1:0]               req_valid_i,
  input  spa_t_u [N_REQ-1:0]             req_spa_i,
  input  mpt_access_e [N_REQ-1:0]        req_access_i,
  output logic [N_REQ-1:0]               req_ready_o,
  output logic                           walker_valid_o,
  output spa_t_u                         walker_spa_o,
  output mpt_access_e                    walker_access_o,
  input  logic                           walker_ready_i,
  input  logic                           walk_done_i,
  input  logic                           access_fault_i,
  input  page_format_fault_e             format_error_i,
  output logic [N_REQ-1:0]               rsp_valid_o,
  output logic                           rsp_access_fault_o,
  output page_format_fault_e             rsp_format_error_o,
  output logic                           busy_o,
  output logic [IDX_W-1:0]               owner_o,
  output mptw_arb_state_e                state_o
);

  mptw_arb_state_e    state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   owner_q;
  spa_t_u             spa_q;
  mpt_access_e        access_q;
  logic [N_REQ-1:0]   rsp_valid_q;
  logic               rsp_af_q;
  page_format_fault_e rsp_fe_q;

  logic [N_REQ-1:0]   sel_grant;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;
  logic               grant_en;
  logic               done_fire;
  logic [N_REQ-1:0]   owner_oh;
  logic [IDX_W-1:0]   rr_ptr_next;

  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .valid (req_valid_i),
    .ptr   (rr_ptr_q),
    .grant (sel_grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  assign owner_oh    = N_REQ'(1) << owner_q;
  assign rr_ptr_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  // Next-state logic; flush always returns to IDLE and wins over walk_done.
  always_comb begin
    state_d   = state_q;
    grant_en  = 1'b0;
    done_fire = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (!flush_i && mptw_enable_i && sel_any) begin
          grant_en = 1'b1;
          state_d  = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (flush_i)             state_d = ARB_IDLE;
        else if (walker_ready_i) state_d = ARB_BUSY;
      end
      ARB_BUSY: begin
        if (flush_i) begin
          state_d = ARB_IDLE;
        end else if (walk_done_i) begin
          done_fire = 1'b1;
          state_d   = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, latched transaction, owner, pointer and registered response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      spa_q       <= '0;
      access_q    <= MPT_ACCESS_READ;
      rsp_valid_q <= '0;
      rsp_af_q    <= 1'b0;
      rsp_fe_q    <= FMT_NO_FAULT;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= done_fire ? owner_oh : '0;
      if (grant_en) begin
        spa_q    <= req_spa_i[sel_idx];
        access_q <= req_access_i[sel_idx];
        owner_q  <= sel_idx;
      end
      if (done_fire) begin
        rsp_af_q <= access_fault_i;
        rsp_fe_q <= format_error_i;
        rr_ptr_q <= rr_ptr_next;
      end
    end
  end

  // The accept pulse is combinational, so it is also gated by reset to keep
  // every output low while reset is held.
  assign req_ready_o        = (grant_en && rst_ni) ? sel_grant : '0;
  assign walker_valid_o     = (state_q == ARB_ISSUE) && !flush_i;
  assign walker_spa_o       = spa_q;
  assign walker_access_o    = access_q;
  assign rsp_valid_o        = flush_i ? '0 : rsp_valid_q;
  assign rsp_access_fault_o = rsp_af_q;
  assign rsp_format_error_o = rsp_fe_q;
  assign busy_o             = (state_q != ARB_IDLE);
  assign owner_o            = owner_q;
  assign state_o            = state_q;

endmodule
